display_scan_controller: RTL and testbench

Sequential controller that converts a binary count into BCD digits and drives the enable and digit inputs of a bank of seven-segment decoder instances (one per display digit). It accepts a new value through a valid/ready handshake, runs a multi-cycle shift-add-3 (double-dabble) conversion, applies saturation and leading-zero blanking, and then updates all digit outputs atomically. It sits between the game/score logic and the per-digit seven-segment decoders on the board's HEX displays.

---
 rtl/display_scan_controller.sv | 187 ++++++++++++++++++
 tb/tb_display_scan_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Binary-to-BCD display controller: accepts a value over valid/ready, runs a serial
// double-dabble conversion, then updates all digit outputs at once. Optional blink: DISPLAY_BLINK_EN.
module display_scan_controller #(
    parameter int DIGITS    = 4,
    parameter int WIDTH     = 14,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [WIDTH-1:0]      value,
    input  logic                  blank_lz,
`ifdef DISPLAY_BLINK_EN
    input  logic                  blink,
`endif
    output logic [4*DIGITS-1:0]   digit_bcd,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  overflow,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int k = 0; k < n; k++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam longint unsigned MAX_VAL  = pow10(DIGITS) - 1;
    localparam logic [WIDTH-1:0] SAT_VAL = WIDTH'(MAX_VAL);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_t;

    state_t state_q, state_d;

    logic                 accept, shift_en, commit_en;
    logic                 sat;
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [BCD_W-1:0]     bcd_adj;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 blank_q, blank_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]     digit_bcd_q, digit_bcd_d;
    logic [DIGITS-1:0]    digit_en_q, digit_en_d;
    logic                 overflow_q, overflow_d;
    logic [DIGITS-1:0]    nz;
    logic [DIGITS-1:0]    en_commit;

    // Values that cannot fit in DIGITS decimal digits are clamped to all nines.
    assign sat = (64'(value) > 64'(MAX_VAL));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (load_valid) state_d = S_SHIFT;
            S_SHIFT:  if (cnt_q == LAST_SHIFT) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state_q == S_IDLE);
        busy       = ~load_ready;
        accept     = load_ready & load_valid;
        shift_en   = (state_q == S_SHIFT);
        commit_en  = (state_q == S_COMMIT);
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? (bcd_q[4*gi +: 4] + 4'd3)
                                                                 : bcd_q[4*gi +: 4];
            assign nz[gi] = |bcd_q[4*gi +: 4];
            // A digit stays lit if blanking is off or any digit at or above it is nonzero.
            if (gi == 0) begin : g_lsd
                assign en_commit[gi] = 1'b1;
            end else begin : g_upper
                assign en_commit[gi] = ~blank_q | (|nz[DIGITS-1:gi]);
            end
        end
    endgenerate

    always_comb begin
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        blank_d     = blank_q;
        ovf_pend_d  = ovf_pend_q;
        digit_bcd_d = digit_bcd_q;
        digit_en_d  = digit_en_q;
        overflow_d  = overflow_q;
        if (accept) begin
            bin_d      = sat ? SAT_VAL : value;
            bcd_d      = '0;
            cnt_d      = '0;
            blank_d    = blank_lz;
            ovf_pend_d = sat;
        end else if (shift_en) begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d          = cnt_q + CNT_W'(1);
        end
        if (commit_en) begin
            digit_bcd_d = bcd_q;
            digit_en_d  = en_commit;
            overflow_d  = ovf_pend_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            blank_q     <= 1'b0;
            ovf_pend_q  <= 1'b0;
            digit_bcd_q <= '0;
            digit_en_q  <= DIGITS'(1);
            overflow_q  <= 1'b0;
        end else begin
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            blank_q     <= blank_d;
            ovf_pend_q  <= ovf_pend_d;
            digit_bcd_q <= digit_bcd_d;
            digit_en_q  <= digit_en_d;
            overflow_q  <= overflow_d;
        end
    end

    assign digit_bcd = digit_bcd_q;
    assign overflow  = overflow_q;

`ifdef DISPLAY_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        phase_d     = phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign digit_en = (blink && phase_q) ? '0 : digit_en_q;
`else
    assign digit_en = digit_en_q;
`endif

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller: decimal reference model checked every cycle,
// plus directed literal expectations. Blink checks are active when DISPLAY_BLINK_EN is defined.
module tb_display_scan_controller;

    localparam int DIGITS    = 4;
    localparam int WIDTH     = 14;
    localparam int BLINK_DIV = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 load_valid = 1'b0;
    logic                 load_ready;
    logic [WIDTH-1:0]     value = '0;
    logic                 blank_lz = 1'b0;
`ifdef DISPLAY_BLINK_EN
    logic                 blink = 1'b0;
`endif
    logic [4*DIGITS-1:0]  digit_bcd;
    logic [DIGITS-1:0]    digit_en;
    logic                 overflow;
    logic                 busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    display_scan_controller #(
        .DIGITS(DIGITS), .WIDTH(WIDTH), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .value(value),
        .blank_lz(blank_lz),
`ifdef DISPLAY_BLINK_EN
        .blink(blink),
`endif
        .digit_bcd(digit_bcd),
        .digit_en(digit_en),
        .overflow(overflow),
        .busy(busy)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain decimal arithmetic on the accepted value.
    function automatic void expect_of(input int v, input bit b, output logic [15:0] bcd,
                                      output logic [3:0] en, output logic ovf);
        int p;
        int vv;
        vv  = v;
        ovf = (vv > 9999);
        if (ovf) vv = 9999;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            bcd[4*i +: 4] = 4'((vv / p) % 10);
            en[i]         = (i == 0) || !b || (vv >= p);
            p             = p * 10;
        end
    endfunction

    int           m_remain = 0;
    int           m_edges = 0;
    logic [15:0]  m_bcd = '0, p_bcd = '0;
    logic [3:0]   m_en = 4'b0001, p_en = '0;
    logic         m_ovf = 1'b0, p_ovf = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_remain = 0;
            m_edges  = 0;
            m_bcd    = '0;
            m_en     = 4'b0001;
            m_ovf    = 1'b0;
        end else begin
            m_edges++;
            if (m_remain > 0) begin
                m_remain--;
                if (m_remain == 0) begin
                    m_bcd = p_bcd;
                    m_en  = p_en;
                    m_ovf = p_ovf;
                end
            end else if (load_valid) begin
                expect_of(int'(value), blank_lz, p_bcd, p_en, p_ovf);
                m_remain = WIDTH + 1;
            end
        end
    end

    always @(posedge clk) begin
        logic [3:0] exp_en;
        #1;
        if (!reset) begin
            exp_en = m_en;
`ifdef DISPLAY_BLINK_EN
            if (blink && (((m_edges / BLINK_DIV) % 2) == 1)) exp_en = '0;
`endif
            chk("cyc_ready", load_ready, (m_remain == 0));
            chk("cyc_busy", busy, (m_remain != 0));
            chk("cyc_bcd", digit_bcd, m_bcd);
            chk("cyc_en", digit_en, exp_en);
            chk("cyc_ovf", overflow, m_ovf);
        end
    end

    task automatic send(input int v, input bit b, output int low);
        @(negedge clk);
        value      = WIDTH'(v);
        blank_lz   = b;
        load_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        low = 0;
        while (!load_ready && low < 100) begin
            low++;
            @(negedge clk);
        end
        if (low >= 100) chk("ready_timeout", low, 15);
        $display("value=%0d blank=%0b -> bcd=0x%04h en=%04b ovf=%0b ready_low=%0d",
                 v, b, digit_bcd, digit_en, overflow, low);
    endtask

    initial begin
        int low;
        int n;
`ifdef DISPLAY_BLINK_EN
        int zeros;
`endif
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_bcd", digit_bcd, 16'h0000);
        chk("rst_en", digit_en, 4'b0001);
        chk("rst_ovf", overflow, 0);
        chk("rst_ready", load_ready, 1);

        send(1234, 1'b1, low);
        chk("lat_1234", low, 15);
        chk("bcd_1234", digit_bcd, 16'h1234);
        chk("en_1234", digit_en, 4'b1111);

        send(7, 1'b1, low);
        chk("bcd_7_blank", digit_bcd, 16'h0007);
        chk("en_7_blank", digit_en, 4'b0001);
        send(7, 1'b0, low);
        chk("en_7_noblank", digit_en, 4'b1111);

        send(12000, 1'b0, low);
        chk("bcd_sat", digit_bcd, 16'h9999);
        chk("ovf_sat", overflow, 1);
        send(0, 1'b1, low);
        chk("bcd_zero", digit_bcd, 16'h0000);
        chk("ovf_zero", overflow, 0);
        chk("en_zero", digit_en, 4'b0001);

        send(10, 1'b1, low);
        chk("en_10", digit_en, 4'b0011);
        send(9999, 1'b1, low);
        chk("ovf_9999", overflow, 0);

        // load_valid held: the second value must wait for the first to commit
        @(negedge clk);
        value      = WIDTH'(4321);
        blank_lz   = 1'b0;
        load_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        value = WIDTH'(5555);
        n = 0;
        while (digit_bcd != 16'h4321 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hold_first_4321", digit_bcd, 16'h4321);
        n = 0;
        while (digit_bcd != 16'h5555 && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) load_valid = 1'b0;
        end
        chk("hold_gap", n, 16);
        $display("held valid: 0x4321 then 0x5555 after %0d cycles", n);

        // reset in the middle of a conversion
        @(negedge clk);
        value      = WIDTH'(9876);
        load_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_bcd", digit_bcd, 16'h0000);
        chk("midrst_en", digit_en, 4'b0001);
        chk("midrst_ovf", overflow, 0);
        chk("midrst_ready", load_ready, 1);
        chk("midrst_busy", busy, 0);
        $display("reset mid-conversion -> bcd=0x%04h en=%04b ovf=%0b", digit_bcd, digit_en, overflow);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_bcd", digit_bcd, 16'h0000);

        send(42, 1'b1, low);
        chk("bcd_42", digit_bcd, 16'h0042);
        chk("en_42", digit_en, 4'b0011);

`ifdef DISPLAY_BLINK_EN
        @(negedge clk);
        blink = 1'b1;
        zeros = 0;
        repeat (16) begin
            @(negedge clk);
            if (digit_en == '0) zeros++;
            chk("blink_bcd", digit_bcd, 16'h0042);
        end
        chk("blink_zeros", zeros, 8);
        $display("blink: %0d of 16 cycles blanked", zeros);
        blink = 1'b0;
        repeat (2) @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
